univ_shift_reg: RTL and testbench
=================================

// Module: univ_shift_reg
// PURPOSE
//  Parametrised universal register: WIDTH-bit D-register bank with async reset, sync set,
//  parallel load, shift/rotate/arithmetic-shift modes and an autonomous N-step burst shifter.
//  Successor of the single-bit set/reset D flip-flop. Used as the serialiser/deserialiser and
//  general-purpose state register in the sequential-circuit library.
// PARAMETERS
//  WIDTH      8      register width in bits, >= 2
//  CNT_W      4      width of burst step count; max burst = 2**CNT_W-1
//  RESET_VAL  0      value of q after rst (WIDTH bits)
// PORTS
//  clk     in   1        rising-edge clock
//  rst     in   1        async reset, active-high
//  set     in   1        sync set: q <= all ones
//  en      in   1        single-step enable for mode
//  mode    in   3        operation select (see BEHAVIOUR)
//  d       in   WIDTH    parallel load data
//  sin_r   in   1        serial in, enters at bit 0 on shift-left
//  sin_l   in   1        serial in, enters at bit WIDTH-1 on shift-right
//  start   in   1        start burst of count steps using mode
//  count   in   CNT_W    burst step count
//  q       out  WIDTH    register contents
//  sout_l  out  1        q[WIDTH-1], combinational from q
//  sout_r  out  1        q[0], combinational from q
//  busy    out  1        burst in progress
//  done    out  1        one-cycle pulse, burst completed
// BEHAVIOUR
//  - rst high (async, any time): q=RESET_VAL, busy=0, done=0, state IDLE, step counter=0.
//  - Modes, applied on one clk edge:
//      000 HOLD  q unchanged              001 SHL  q <= {q[W-2:0], sin_r}
//      010 SHR   q <= {sin_l, q[W-1:1]}   011 LOAD q <= d
//      100 ROL   q <= {q[W-2:0], q[W-1]}  101 ROR  q <= {q[0], q[W-1:1]}
//      110 ASR   q <= {q[W-1], q[W-1:1]}  111 CLR  q <= 0
//  - Priority per edge: set > burst step (state SHIFT) > start acceptance > en/mode > hold.
//  - IDLE, en=1, start=0: apply mode once per edge; latency 1 clk. en=0: hold.
//  - FSM: IDLE, SHIFT.
//    IDLE->SHIFT: start=1, count!=0, mode in {001,010,100,101,110}; latch mode and count,
//      busy=1 from that edge. Start edge itself performs no shift; en is ignored.
//    start with count=0 and a shift mode: no state change, done=1 for the next cycle.
//    start with a non-shift mode (000/011/111): ignored, single-step rules apply if en=1.
//    SHIFT: one step of the latched mode per edge; sin_l/sin_r sampled live each edge.
//      Inputs mode/en/count/start ignored while busy (start mid-burst dropped).
//    SHIFT->IDLE: on the edge performing the last step: busy=0, done=1 for exactly one cycle.
//    Burst of N steps: busy high N cycles; done high in cycle N+1 after start edge.
//  - set=1 at an edge: q=all ones; if in SHIFT, burst aborts to IDLE, busy=0, no done.
//  - rst mid-burst: immediate abort, all outputs to reset values, no done.
//  - Step counter is CNT_W bits, counts down, no wrap; max burst 2**CNT_W-1.
//  - Rotation/shift wrap only as defined by mode; no carry/overflow output.
// TESTING
//  1 rst=1 then release; WIDTH=8, RESET_VAL=8'h00 -> q=00, busy=0, done=0; rst async mid-cycle clears q.
//  2 LOAD d=8'hA5; SHL sin_r=1 -> 4B; ROR -> A5; ASR on 8'h80 x2 -> C0, E0.
//  3 q=8'h81, mode=ROL, start, count=3 -> busy 3 cycles, q=0C, done 1 cycle, then busy=0.
//  4 Burst SHR count=5 from 8'hFF, set=1 on 2nd step -> q=FF, busy=0, done never asserted.
//  5 start with count=0 (SHL) -> q unchanged, done pulses once, busy stays 0;
//    start with mode=LOAD -> no burst.
//  6 rst asserted mid-burst then released; new burst count=15 runs to completion;
//    start during busy ignored; done single pulse.

Source files
------------

// File: rtl/univ_shift_reg.sv
`default_nettype none
// ============================================================================
// Module   : univ_shift_reg
// Brief    : WIDTH-bit universal register. It supports parallel load, shift,
//            rotate, arithmetic shift, synchronous set, and an autonomous
//            N-step burst shifter.
// Revision : 1.0 - initial release
// ============================================================================
module univ_shift_reg #(
    parameter int                 WIDTH     = 8,
    parameter int                 CNT_W     = 4,
    parameter logic [WIDTH-1:0]   RESET_VAL = '0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             set,
    input  logic             en,
    input  logic [2:0]       mode,
    input  logic [WIDTH-1:0] d,
    input  logic             sin_r,
    input  logic             sin_l,
    input  logic             start,
    input  logic [CNT_W-1:0] count,
    output logic [WIDTH-1:0] q,
    output logic             sout_l,
    output logic             sout_r,
    output logic             busy,
    output logic             done
);

    localparam logic [2:0] c_hold = 3'b000;
    localparam logic [2:0] c_shl  = 3'b001;
    localparam logic [2:0] c_shr  = 3'b010;
    localparam logic [2:0] c_load = 3'b011;
    localparam logic [2:0] c_rol  = 3'b100;
    localparam logic [2:0] c_ror  = 3'b101;
    localparam logic [2:0] c_asr  = 3'b110;
    localparam logic [2:0] c_clr  = 3'b111;

    localparam logic [CNT_W-1:0] c_cnt_one = {{(CNT_W-1){1'b0}}, 1'b1};

    typedef enum logic [0:0] {
        ST_IDLE  = 1'b0,
        ST_SHIFT = 1'b1
    } state_t;

    state_t           r_state, w_state_nxt;
    logic [WIDTH-1:0] r_q,     w_q_nxt;
    logic [CNT_W-1:0] r_cnt,   w_cnt_nxt;
    logic [2:0]       r_mode,  w_mode_nxt;
    logic             r_done,  w_done_nxt;
    logic             w_start_shift_mode;

    // One operation of the selected mode applied to the current contents.
    function automatic logic [WIDTH-1:0] f_apply(
        input logic [2:0]       op,
        input logic [WIDTH-1:0] cur,
        input logic [WIDTH-1:0] ld,
        input logic             s_r,
        input logic             s_l
    );
        logic [WIDTH-1:0] res;
        res = cur;
        case (op)
            c_hold: res = cur;
            c_shl:  res = {cur[WIDTH-2:0], s_r};
            c_shr:  res = {s_l, cur[WIDTH-1:1]};
            c_load: res = ld;
            c_rol:  res = {cur[WIDTH-2:0], cur[WIDTH-1]};
            c_ror:  res = {cur[0], cur[WIDTH-1:1]};
            c_asr:  res = {cur[WIDTH-1], cur[WIDTH-1:1]};
            c_clr:  res = '0;
            default: res = cur;
        endcase
        return res;
    endfunction

    // Only the true shift/rotate modes can start a burst.
    assign w_start_shift_mode = (mode == c_shl) || (mode == c_shr) ||
                                (mode == c_rol) || (mode == c_ror) ||
                                (mode == c_asr);

    // State, contents and burst bookkeeping registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= ST_IDLE;
            r_q     <= RESET_VAL;
            r_cnt   <= '0;
            r_mode  <= c_hold;
            r_done  <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_q     <= w_q_nxt;
            r_cnt   <= w_cnt_nxt;
            r_mode  <= w_mode_nxt;
            r_done  <= w_done_nxt;
        end
    end

    // Next-state logic. Priority is set, then burst step, then start, then en.
    always_comb begin
        w_state_nxt = r_state;
        w_q_nxt     = r_q;
        w_cnt_nxt   = r_cnt;
        w_mode_nxt  = r_mode;
        w_done_nxt  = 1'b0;
        if (set) begin
            // Set aborts any burst silently, so no done pulse is produced.
            w_q_nxt     = '1;
            w_state_nxt = ST_IDLE;
            w_cnt_nxt   = '0;
        end else if (r_state == ST_SHIFT) begin
            w_q_nxt = f_apply(r_mode, r_q, d, sin_r, sin_l);
            if (r_cnt == c_cnt_one) begin
                w_state_nxt = ST_IDLE;
                w_cnt_nxt   = '0;
                w_done_nxt  = 1'b1;
            end else begin
                w_cnt_nxt = r_cnt - c_cnt_one;
            end
        end else if (start && w_start_shift_mode) begin
            // The start edge only latches the burst; the first step happens on the next edge.
            if (count != '0) begin
                w_state_nxt = ST_SHIFT;
                w_cnt_nxt   = count;
                w_mode_nxt  = mode;
            end else begin
                w_done_nxt = 1'b1;
            end
        end else if (en) begin
            w_q_nxt = f_apply(mode, r_q, d, sin_r, sin_l);
        end
    end

    assign q      = r_q;
    assign sout_l = r_q[WIDTH-1];
    assign sout_r = r_q[0];
    assign busy   = (r_state == ST_SHIFT);
    assign done   = r_done;

endmodule
`default_nettype wire

// File: tb/tb_univ_shift_reg.sv
`default_nettype none
// ============================================================================
// Module   : tb_univ_shift_reg
// Brief    : Directed self-checking bench for univ_shift_reg.
// Revision : 1.0 - initial release
// ============================================================================
module tb_univ_shift_reg;

    logic       clk;
    logic       rst;
    logic       set;
    logic       en;
    logic [2:0] mode;
    logic [7:0] d;
    logic       sin_r;
    logic       sin_l;
    logic       start;
    logic [3:0] count;
    logic [7:0] q;
    logic       sout_l;
    logic       sout_r;
    logic       busy;
    logic       done;

    int n_vec;
    int n_err;
    int busy_cycles;
    int done_pulses;

    univ_shift_reg #(
        .WIDTH     (8),
        .CNT_W     (4),
        .RESET_VAL (8'h00)
    ) u_dut (
        .clk    (clk),
        .rst    (rst),
        .set    (set),
        .en     (en),
        .mode   (mode),
        .d      (d),
        .sin_r  (sin_r),
        .sin_l  (sin_l),
        .start  (start),
        .count  (count),
        .q      (q),
        .sout_l (sout_l),
        .sout_r (sout_r),
        .busy   (busy),
        .done   (done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [7:0] got, input logic [7:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Advance one clock edge and settle away from it.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        set = 0; en = 0; mode = 3'b000; d = 8'h00;
        sin_r = 0; sin_l = 0; start = 0; count = 4'd0;
    endtask

    task automatic load(input logic [7:0] val);
        idle_inputs();
        en = 1; mode = 3'b011; d = val;
        step();
        idle_inputs();
    endtask

    initial begin
        n_vec = 0;
        n_err = 0;
        idle_inputs();
        rst = 1;

        // 1: reset state and asynchronous clear
        step();
        chk("rst_q", q, 8'h00);
        chk("rst_busy", {7'b0, busy}, 8'h00);
        chk("rst_done", {7'b0, done}, 8'h00);
        rst = 0;
        load(8'h5A);
        chk("load_5a", q, 8'h5A);
        #3 rst = 1;
        #1 chk("async_rst_q", q, 8'h00);
        rst = 0;

        // 2: single-step modes
        load(8'hA5);
        chk("load_a5", q, 8'hA5);
        chk("sout_l", {7'b0, sout_l}, 8'h01);
        chk("sout_r", {7'b0, sout_r}, 8'h01);
        en = 1; mode = 3'b001; sin_r = 1; step();
        chk("shl", q, 8'h4B);
        mode = 3'b101; sin_r = 0; step();
        chk("ror", q, 8'hA5);
        en = 0; mode = 3'b111; step();
        chk("en0_hold", q, 8'hA5);
        load(8'h80);
        en = 1; mode = 3'b110; step();
        chk("asr1", q, 8'hC0);
        step();
        chk("asr2", q, 8'hE0);
        mode = 3'b010; sin_l = 0; step();
        chk("shr", q, 8'h70);
        mode = 3'b100; step();
        chk("rol", q, 8'hE0);
        mode = 3'b000; step();
        chk("hold", q, 8'hE0);
        mode = 3'b111; step();
        chk("clr", q, 8'h00);
        set = 1; step();
        chk("set_idle", q, 8'hFF);
        idle_inputs();

        // 3: ROL burst of 3 from 81
        load(8'h81);
        mode = 3'b100; start = 1; count = 4'd3; step();
        chk("b3_start_q", q, 8'h81);
        chk("b3_start_busy", {7'b0, busy}, 8'h01);
        start = 0; en = 1; mode = 3'b000; count = 4'd0;
        step();
        chk("b3_s1", q, 8'h03);
        chk("b3_s1_busy", {7'b0, busy}, 8'h01);
        step();
        chk("b3_s2", q, 8'h06);
        step();
        chk("b3_s3", q, 8'h0C);
        chk("b3_end_busy", {7'b0, busy}, 8'h00);
        chk("b3_done", {7'b0, done}, 8'h01);
        en = 0;
        step();
        chk("b3_done_off", {7'b0, done}, 8'h00);
        chk("b3_hold", q, 8'h0C);

        // 4: SHR burst aborted by set
        load(8'hFF);
        mode = 3'b010; sin_l = 0; start = 1; count = 4'd5; step();
        start = 0;
        step();
        chk("b5_s1", q, 8'h7F);
        set = 1; step();
        set = 0;
        chk("abort_q", q, 8'hFF);
        chk("abort_busy", {7'b0, busy}, 8'h00);
        done_pulses = 0;
        for (int i = 0; i < 6; i++) begin
            if (done) done_pulses++;
            step();
        end
        chk("abort_no_done", done_pulses[7:0], 8'h00);
        chk("abort_q_after", q, 8'hFF);

        // 5: zero-count start and non-shift start
        idle_inputs();
        mode = 3'b001; start = 1; count = 4'd0; sin_r = 0; step();
        start = 0;
        chk("zc_q", q, 8'hFF);
        chk("zc_busy", {7'b0, busy}, 8'h00);
        chk("zc_done", {7'b0, done}, 8'h01);
        step();
        chk("zc_done_off", {7'b0, done}, 8'h00);
        mode = 3'b011; d = 8'h3C; start = 1; count = 4'd4; step();
        chk("ld_start_busy", {7'b0, busy}, 8'h00);
        chk("ld_start_q", q, 8'hFF);
        en = 1; step();
        chk("ld_start_en", q, 8'h3C);
        chk("ld_start_busy2", {7'b0, busy}, 8'h00);
        idle_inputs();

        // 6: reset mid-burst, then a full 15-step burst
        load(8'h01);
        mode = 3'b001; start = 1; count = 4'd4; step();
        start = 0;
        step();
        chk("r_mid_s1", q, 8'h02);
        #2 rst = 1;
        #1 chk("r_mid_q", q, 8'h00);
        chk("r_mid_busy", {7'b0, busy}, 8'h00);
        rst = 0;
        step();
        chk("r_mid_done", {7'b0, done}, 8'h00);
        load(8'h01);
        mode = 3'b100; start = 1; count = 4'd15; step();
        busy_cycles = 0;
        done_pulses = 0;
        // Keep start asserted with a different mode for the early part of the burst.
        mode = 3'b010; count = 4'd2;
        for (int i = 0; i < 18; i++) begin
            if (i == 4) start = 0;
            if (busy) busy_cycles++;
            if (done) done_pulses++;
            step();
            if (i == 14) chk("b15_q", q, 8'h80);
        end
        chk("b15_busy_cycles", busy_cycles[7:0], 8'd15);
        chk("b15_done_pulses", done_pulses[7:0], 8'd1);
        chk("b15_final_busy", {7'b0, busy}, 8'h00);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
`default_nettype wire
